// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: shared bus constants, memory sizing and controller state type
package data_ram_ctrl_pkg;
   localparam int          REG_BUS           = 32;
   localparam int          DATA_MEM_NUM_LOG2 = 10;
   localparam logic        CHIP_ENABLE       = 1'b1;
   localparam logic        WRITE_ENABLE      = 1'b1;
   localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
endpackage

// File: rtl/data_ram_ctrl_array.sv
// data_ram_array: four 8-bit lanes with byte-enable synchronous write and synchronous read
module data_ram_array #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [3:0]    wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);
   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] mem [2**AW];
      logic [7:0] rd_lane;
      // one lane: write when its sel bit is set, register the word at a read issue
      always_ff @(posedge clk) begin
         if (wr_en && wr_sel[i]) mem[wr_addr] <= wr_data[8*i +: 8];
         if (rd_en) rd_lane <= mem[rd_addr];
      end
      assign rd_data[8*i +: 8] = rd_lane;
   end
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: MEM-stage data memory responder with wait-state reads and pipeline stall
module data_ram_ctrl
   import data_ram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = DATA_MEM_NUM_LOG2,
   parameter int WAIT_CYCLES = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               we,
   input  logic [REG_BUS-1:0] addr,
   input  logic [3:0]         sel,
   input  logic [REG_BUS-1:0] data_i,
   input  logic               flush,
   output logic [REG_BUS-1:0] data_o,
   output logic               stallreq
);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   state_t                  state, state_n;
   logic [3:0]              cnt, cnt_n;
   logic                    wr_en, rd_en, stall;
   logic [REG_BUS-1:0]      rd_word, data_q;
   logic [ADDR_WIDTH-1:0]   word_addr;
   logic                    unused_addr_bits;
   assign word_addr        = addr[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{addr[REG_BUS-1:ADDR_WIDTH+2], addr[1:0]};
   // next state, wait counter and strobes; flush forces a return to IDLE with nothing issued
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      stall   = 1'b0;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (ce == CHIP_ENABLE) begin
                  if (we == WRITE_ENABLE) begin
                     wr_en = 1'b1;
                  end else begin
                     stall = 1'b1;
                     if (WAIT_CYCLES == 0) begin
                        rd_en   = 1'b1;
                        state_n = RD_DONE;
                     end else begin
                        cnt_n   = WAIT_LOAD;
                        state_n = RD_WAIT;
                     end
                  end
               end
            end
            RD_WAIT: begin
               stall = 1'b1;
               if (cnt == 4'd0) begin
                  rd_en   = 1'b1;
                  state_n = RD_DONE;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
   // state, counter and held read data; reset aborts any read in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         data_q <= ZERO_WORD;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == RD_DONE && !flush) data_q <= rd_word;
      end
   end
   data_ram_array #(.AW(ADDR_WIDTH)) u_array (
      .clk     (clk),
      .wr_en   (rst & wr_en),
      .wr_sel  (sel),
      .wr_addr (word_addr),
      .wr_data (data_i),
      .rd_en   (rst & rd_en),
      .rd_addr (word_addr),
      .rd_data (rd_word)
   );
   assign data_o   = (state == RD_DONE && !flush) ? rd_word : data_q;
   assign stallreq = rst & stall;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed and randomized checks of data_ram_ctrl against a word-array model
module tb_data_ram_ctrl;
   logic        clk = 1'b0, rst = 1'b1, ce0 = 1'b0, ce3 = 1'b0, we = 1'b0, flush = 1'b0;
   logic [31:0] addr = '0, data_i = '0;
   logic [3:0]  sel = '0;
   logic [31:0] data_o0, data_o3;
   logic        stall0, stall3;
   int          checks = 0, failures = 0;
   logic [31:0] model [1024];

   always #5 clk = ~clk;

   data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .ce(ce0), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .flush(flush), .data_o(data_o0), .stallreq(stall0));
   data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .ce(ce3), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .flush(flush), .data_o(data_o3), .stallreq(stall3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // write to both instances; a flushed write must leave memory untouched
   task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic fl);
      @(negedge clk);
      ce0 = 1'b1; ce3 = 1'b1; we = 1'b1; addr = a; sel = s; data_i = d; flush = fl;
      #1;
      chk("wr_stall0", {31'b0, stall0}, 32'd0);
      chk("wr_stall3", {31'b0, stall3}, 32'd0);
      @(negedge clk);
      ce0 = 1'b0; ce3 = 1'b0; we = 1'b0; flush = 1'b0;
      if (!fl)
         for (int b = 0; b < 4; b++)
            if (s[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   // read from the instance with w wait states; checks stall length, data and hold
   task automatic do_read(input int w, input logic [31:0] a, output logic [31:0] got);
      int n;
      @(negedge clk);
      we = 1'b0; addr = a; sel = 4'($urandom);
      if (w == 0) ce0 = 1'b1; else ce3 = 1'b1;
      #1;
      n = 0;
      while (((w == 0) ? stall0 : stall3) && n < 20) begin
         n++;
         @(negedge clk);
         #1;
      end
      got = (w == 0) ? data_o0 : data_o3;
      chk("rd_stall_cycles", 32'(n), 32'(w + 1));
      chk("rd_data", got, model[a[11:2]]);
      ce0 = 1'b0; ce3 = 1'b0;
      @(negedge clk);
      #1;
      chk("rd_hold", (w == 0) ? data_o0 : data_o3, got);
      chk("rd_idle_stall", {31'b0, (w == 0) ? stall0 : stall3}, 32'd0);
   endtask

   initial begin
      logic [31:0] got, prev, a;
      for (int i = 0; i < 1024; i++) model[i] = '0;
      #1 rst = 1'b0;
      ce0 = 1'b1; ce3 = 1'b1; we = 1'b0;
      #12;
      chk("reset_stall0", {31'b0, stall0}, 32'd0);
      chk("reset_stall3", {31'b0, stall3}, 32'd0);
      chk("reset_data0", data_o0, 32'd0);
      chk("reset_data3", data_o3, 32'd0);
      ce0 = 1'b0; ce3 = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      do_write(32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
      do_read(0, 32'h10, got);
      chk("sw_lw", got, 32'hDEADBEEF);

      do_write(32'h20, 4'b1111, 32'h11223344, 1'b0);
      do_write(32'h20, 4'b0100, 32'hAAAAAAAA, 1'b0);
      do_read(3, 32'h20, got);
      chk("lane_write", got, 32'h11AA3344);
      do_write(32'h20, 4'b0000, 32'h55555555, 1'b0);
      do_read(0, 32'h20, got);
      chk("sel_zero_noop", got, 32'h11AA3344);
      do_write(32'h24, 4'b1111, 32'hCAFEF00D, 1'b0);
      chk("hold_through_write", data_o0, 32'h11AA3344);
      do_write(32'h20, 4'b1111, 32'h12345678, 1'b1);
      do_read(3, 32'h20, got);
      chk("flush_idle_write", got, 32'h11AA3344);

      prev = data_o3;
      @(negedge clk);
      ce3 = 1'b1; we = 1'b0; addr = 32'h10;
      #1 chk("flush_rd_stall1", {31'b0, stall3}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_rd_stall2", {31'b0, stall3}, 32'd0);
      chk("flush_rd_data", data_o3, prev);
      @(negedge clk);
      flush = 1'b0; ce3 = 1'b0;
      #1 chk("flush_rd_idle", {31'b0, stall3}, 32'd0);
      chk("flush_rd_data_idle", data_o3, prev);

      @(negedge clk);
      ce3 = 1'b1; we = 1'b0; addr = 32'h20;
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("rst_mid_stall", {31'b0, stall3}, 32'd0);
      chk("rst_mid_data3", data_o3, 32'd0);
      chk("rst_mid_data0", data_o0, 32'd0);
      ce3 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      do_write(32'h0, 4'b1111, 32'h5, 1'b0);
      do_read(0, 32'h1000, got);
      chk("alias0", got, 32'h5);
      do_read(3, 32'h1000, got);
      chk("alias3", got, 32'h5);

      for (int i = 0; i < 16; i++) begin
         a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2) | 32'($urandom_range(0, 3));
         do_write(a, 4'b1111, $urandom, 1'b0);
      end
      for (int k = 0; k < 40; k++) begin
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) do_write(a, 4'($urandom), $urandom, 1'($urandom_range(0, 7) == 0));
         else do_read(($urandom_range(0, 1) == 0) ? 0 : 3, a, got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
